// File: rtl/div32u16_seq_pkg.sv
// div_pkg: shared types and constants for the sequential 32/16 unsigned divider
package div_pkg;
   localparam int DW = 32;
   localparam int QW = 16;
   localparam int CW = 5;
   localparam logic [QW-1:0] QSAT = 16'hFFFF;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/div32u16_seq_if.sv
// div32u16_seq_if: operand/result valid-ready bundle for the divider
interface div32u16_seq_if;
   import div_pkg::*;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] A;
   logic [QW-1:0] B;
   logic          out_valid;
   logic          out_ready;
   logic [QW-1:0] Q;
   logic [QW-1:0] R;
   logic          div_by_zero;
   logic          overflow;
   modport master (output in_valid, A, B, out_ready,
                   input in_ready, out_valid, Q, R, div_by_zero, overflow);
   modport slave  (input in_valid, A, B, out_ready,
                   output in_ready, out_valid, Q, R, div_by_zero, overflow);
endinterface

// File: rtl/div32u16_seq_step.sv
// div_step: one restoring-division iteration (shift in a dividend bit, trial subtract)
module div_step
   import div_pkg::*;
(
   input  logic [16:0]   rem,
   input  logic          bit_in,
   input  logic [QW-1:0] dsr,
   output logic [16:0]   rem_nxt,
   output logic          qbit
);
   logic [17:0] t;
   logic [17:0] d;
   // the borrow out of the 18-bit trial subtract is the inverted quotient bit
   always_comb begin
      t       = {rem, bit_in};
      d       = t - {2'b00, dsr};
      qbit    = ~d[17];
      rem_nxt = qbit ? d[16:0] : t[16:0];
   end
endmodule

// File: rtl/div32u16_seq.sv
// div32u16_seq: radix-2 restoring 32/16 unsigned divider with optional quotient truncation
module div32u16_seq
   import div_pkg::*;
#(
   parameter int TRUNC = 0
)
(
   input  logic           clk,
   input  logic           rst_n,
   div32u16_seq_if.slave  io
);
   localparam int N = QW - TRUNC;
   state_t        state;
   logic [16:0]   rem;
   logic [16:0]   rem_nxt;
   logic [QW-1:0] dsr;
   logic [QW-1:0] bsave;
   logic [QW-1:0] quot;
   logic [QW-1:0] q_r;
   logic [QW-1:0] r_r;
   logic [CW-1:0] cnt;
   logic          qbit;
   logic          dbz_r;
   logic          ovf_r;
   div_step u_step (
      .rem     (rem),
      .bit_in  (dsr[QW-1]),
      .dsr     (bsave),
      .rem_nxt (rem_nxt),
      .qbit    (qbit)
   );
   assign io.in_ready    = state == IDLE;
   assign io.out_valid   = state == DONE;
   assign io.Q           = q_r;
   assign io.R           = r_r;
   assign io.div_by_zero = dbz_r;
   assign io.overflow    = ovf_r;
   // accept operands, iterate one quotient bit per edge, hold the result until drained
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         rem   <= '0;
         dsr   <= '0;
         bsave <= '0;
         quot  <= '0;
         cnt   <= '0;
         q_r   <= '0;
         r_r   <= '0;
         dbz_r <= 1'b0;
         ovf_r <= 1'b0;
      end else begin
         case (state)
            IDLE: if (io.in_valid) begin
               rem   <= {1'b0, io.A[DW-1:QW]};
               dsr   <= io.A[QW-1:0];
               bsave <= io.B;
               cnt   <= CW'(N);
               quot  <= '0;
               dbz_r <= io.B == '0;
               ovf_r <= io.B != '0 && io.A[DW-1:QW] >= io.B;
               if (io.B == '0) begin
                  q_r   <= QSAT;
                  r_r   <= io.A[QW-1:0];
                  state <= DONE;
               end else if (io.A[DW-1:QW] >= io.B) begin
                  q_r   <= QSAT;
                  r_r   <= '0;
                  state <= DONE;
               end else begin
                  state <= CALC;
               end
            end
            CALC: begin
               rem  <= rem_nxt;
               dsr  <= dsr << 1;
               quot <= {quot[QW-2:0], qbit};
               cnt  <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  q_r   <= {quot[QW-2:0], qbit} << TRUNC;
                  r_r   <= TRUNC == 0 ? rem_nxt[QW-1:0] : '0;
                  state <= DONE;
               end
            end
            DONE: if (io.out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div32u16_seq.sv
// tb_div32u16_seq: randomized self-checking bench for exact (TRUNC=0) and truncated (TRUNC=4) dividers
module tb_div32u16_seq;
   import div_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   div32u16_seq_if io0 ();
   div32u16_seq_if io4 ();
   div32u16_seq #(.TRUNC(0)) u0 (.clk(clk), .rst_n(rst_n), .io(io0));
   div32u16_seq #(.TRUNC(4)) u4 (.clk(clk), .rst_n(rst_n), .io(io4));
   logic [31:0] a = '0;
   logic [15:0] b = '0;
   logic        iv [2];
   logic        ordy [2];
   logic        vld [2];
   logic        rdy [2];
   logic        dz [2];
   logic        of [2];
   logic [15:0] q [2];
   logic [15:0] r [2];
   logic [15:0] eq [2];
   logic [15:0] er [2];
   logic        ed [2];
   logic        eo [2];
   logic        live [2];
   logic [15:0] lq;
   logic [15:0] lr;
   logic        ld;
   logic        lo;
   int checks = 0;
   int failures = 0;
   assign io0.in_valid  = iv[0];
   assign io0.A         = a;
   assign io0.B         = b;
   assign io0.out_ready = ordy[0];
   assign io4.in_valid  = iv[1];
   assign io4.A         = a;
   assign io4.B         = b;
   assign io4.out_ready = ordy[1];
   assign vld[0] = io0.out_valid;
   assign rdy[0] = io0.in_ready;
   assign q[0]   = io0.Q;
   assign r[0]   = io0.R;
   assign dz[0]  = io0.div_by_zero;
   assign of[0]  = io0.overflow;
   assign vld[1] = io4.out_valid;
   assign rdy[1] = io4.in_ready;
   assign q[1]   = io4.Q;
   assign r[1]   = io4.R;
   assign dz[1]  = io4.div_by_zero;
   assign of[1]  = io4.overflow;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // expected result from plain arithmetic; ml = edges from the accepting edge to out_valid
   function automatic void model(input int tr, input logic [31:0] x, input logic [15:0] y,
                                 output logic [15:0] mq, output logic [15:0] mr,
                                 output logic md, output logic mo, output int ml);
      longint ex;
      md = 1'b0;
      mo = 1'b0;
      ml = 0;
      mq = '0;
      mr = '0;
      if (y == 0) begin
         mq = 16'hFFFF;
         mr = x[15:0];
         md = 1'b1;
      end else begin
         ex = longint'(x) / longint'(y);
         if (ex > 65535) begin
            mq = 16'hFFFF;
            mo = 1'b1;
         end else begin
            mq = 16'((ex >> tr) << tr);
            mr = tr == 0 ? 16'(longint'(x) % longint'(y)) : 16'h0;
            ml = 16 - tr;
         end
      end
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         for (int s = 0; s < 2; s++) begin
            if (vld[s]) begin
               chk("valid_expected", live[s], 1);
               if (live[s]) begin
                  chk("Q", q[s], eq[s]);
                  chk("R", r[s], er[s]);
                  chk("div_by_zero", dz[s], ed[s]);
                  chk("overflow", of[s], eo[s]);
               end
            end
         end
      end
   end

   task automatic do_op(input int s, input logic [31:0] x, input logic [15:0] y, input int hold);
      int ml;
      int k;
      logic [15:0] mq;
      logic [15:0] mr;
      logic md;
      logic mo;
      model(s == 1 ? 4 : 0, x, y, mq, mr, md, mo, ml);
      @(negedge clk);
      chk("in_ready_idle", rdy[s], 1);
      a = x;
      b = y;
      iv[s] = 1'b1;
      eq[s] = mq;
      er[s] = mr;
      ed[s] = md;
      eo[s] = mo;
      live[s] = 1'b1;
      @(posedge clk);
      #1 iv[s] = 1'b0;
      k = 0;
      while (!vld[s] && k < 40) begin
         chk("in_ready_busy", rdy[s], 0);
         @(posedge clk);
         #1 k++;
      end
      chk("latency", k, ml);
      lq = q[s];
      lr = r[s];
      ld = dz[s];
      lo = of[s];
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         iv[s] = 1'($urandom);
         a = $urandom;
         b = 16'($urandom);
         @(posedge clk);
         #1;
         chk("hold_valid", vld[s], 1);
         chk("hold_in_ready", rdy[s], 0);
      end
      @(negedge clk);
      iv[s] = 1'b0;
      ordy[s] = 1'b1;
      @(posedge clk);
      #1 ordy[s] = 1'b0;
      live[s] = 1'b0;
      chk("drain_valid", vld[s], 0);
      chk("drain_in_ready", rdy[s], 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] mq;
      logic [15:0] mr;
      logic md;
      logic mo;
      int ml;
      logic [31:0] aa;
      logic [15:0] bb;
      logic [31:0] ex;
      int s;
      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b0;
         ordy[i] = 1'b0;
         live[i] = 1'b0;
         eq[i] = '0;
         er[i] = '0;
         ed[i] = 1'b0;
         eo[i] = 1'b0;
      end
      model(0, 32'd100, 16'd7, mq, mr, md, mo, ml);
      chk("model_q_100_7", mq, 14);
      chk("model_r_100_7", mr, 2);
      chk("model_lat_100_7", ml, 16);
      model(4, 32'd100000, 16'd3, mq, mr, md, mo, ml);
      chk("model_q_trunc", mq, 16'h8230);
      chk("model_lat_trunc", ml, 12);
      #12;
      for (int i = 0; i < 2; i++) begin
         chk("rst_in_ready", rdy[i], 1);
         chk("rst_out_valid", vld[i], 0);
         chk("rst_Q", q[i], 0);
         chk("rst_R", r[i], 0);
         chk("rst_flags", {dz[i], of[i]}, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_op(0, 32'd100, 16'd7, 5);
      chk("lit_q_100_7", lq, 14);
      chk("lit_r_100_7", lr, 2);
      do_op(0, 32'hFFFE0001, 16'hFFFF, 0);
      chk("lit_q_max", lq, 16'hFFFF);
      chk("lit_r_max", lr, 0);
      chk("lit_ovf_max", lo, 0);
      do_op(0, 32'h00050000, 16'd5, 0);
      chk("lit_ovf", lo, 1);
      chk("lit_ovf_q", lq, 16'hFFFF);
      do_op(0, 32'd1234, 16'd0, 0);
      chk("lit_dbz", ld, 1);
      chk("lit_dbz_r", lr, 16'h04D2);
      do_op(1, 32'd100000, 16'd3, 2);
      chk("lit_trunc_q", lq, 16'h8230);
      chk("lit_trunc_r", lr, 0);
      @(negedge clk);
      a = 32'd1000;
      b = 16'd9;
      iv[0] = 1'b1;
      @(posedge clk);
      #1 iv[0] = 1'b0;
      repeat (8) @(posedge clk);
      #1 chk("mid_calc_valid", vld[0], 0);
      rst_n = 1'b0;
      live[0] = 1'b0;
      #1;
      chk("async_rst_valid", vld[0], 0);
      chk("async_rst_in_ready", rdy[0], 1);
      chk("async_rst_Q", q[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(0, 32'd1000, 16'd9, 0);
      chk("lit_q_1000_9", lq, 111);
      chk("lit_r_1000_9", lr, 1);
      for (int n = 0; n < 60; n++) begin
         s = n % 2;
         bb = ($urandom_range(7) == 0) ? 16'h0 : 16'($urandom);
         if (bb == 0 || $urandom_range(5) == 0) aa = $urandom;
         else aa = {16'($urandom_range(32'(bb) - 1)), 16'($urandom)};
         do_op(s, aa, bb, int'($urandom_range(2)));
         if (s == 1 && !ld && !lo) begin
            ex = aa / {16'h0, bb};
            chk("err_bound", ex >= {16'h0, lq} && ex - {16'h0, lq} < 16, 1);
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
